dot_product_accumulator: RTL and testbench

//  Sequencer and accumulator for one row-by-column dot product in the matrix multiplier.

---
 rtl/dpa_pkg.sv | 19 +
 rtl/dot_product_accumulator.sv | 135 +++++++++++++
 tb/tb_dot_product_accumulator.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dpa_pkg.sv
// Shared types and constants for the dot-product accumulator and its
// sequential multiplier handshake.
package dpa_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      MULT,
      ACC,
      DONE
   } state_e;

   localparam int MUL_CYCLES = 8;
   localparam int MUL_OP_W   = 8;
   localparam int MUL_PROD_W = 16;
   localparam int BIT_CNT_W  = $clog2(MUL_CYCLES);

endpackage

// File: rtl/dot_product_accumulator.sv
// Sequences signed operand pairs through an external sequential multiplier
// and accumulates the sign-extended products into one ACC_W-bit result.
module dot_product_accumulator
   import dpa_pkg::*;
#(
   parameter int LEN_W = 5,
   parameter int ACC_W = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      len,
   output logic                  busy,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MUL_OP_W-1:0]   in_a,
   input  logic [MUL_OP_W-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_sum,
   output logic                  out_ovf,
   output logic [MUL_OP_W-1:0]   mul_a,
   output logic [MUL_OP_W-1:0]   mul_b,
   output logic                  mul_s,
   input  logic [MUL_PROD_W-1:0] mul_q
);

   // Handshake: a pair moves when in_valid && in_ready at a rising edge;
   // a result moves when out_valid && out_ready at a rising edge.

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      elem_cnt_q, elem_cnt_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic                  ovf_q, ovf_d;
   logic [MUL_OP_W-1:0]   mul_a_q, mul_a_d;
   logic [MUL_OP_W-1:0]   mul_b_q, mul_b_d;

   logic signed [MUL_PROD_W-1:0] prod_s;
   logic [ACC_W-1:0]             prod_ext;
   logic [ACC_W-1:0]             sum;
   logic                         add_ovf;

   // Signed size cast sign-extends the product to accumulator width.
   assign prod_s   = mul_q;
   assign prod_ext = ACC_W'(prod_s);
   assign sum      = acc_q + prod_ext;
   assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      elem_cnt_d = elem_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d      = len;
               acc_d      = '0;
               ovf_d      = 1'b0;
               elem_cnt_d = '0;
               state_d    = (len == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (in_valid) begin
               mul_a_d = in_a;
               mul_b_d = in_b;
               state_d = LOAD;
            end
         end
         LOAD: begin
            bit_cnt_d = '0;
            state_d   = MULT;
         end
         MULT: begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(MUL_CYCLES - 1)) begin
               state_d = ACC;
            end
         end
         ACC: begin
            acc_d      = sum;
            ovf_d      = ovf_q | add_ovf;
            elem_cnt_d = elem_cnt_q + LEN_W'(1);
            state_d    = (elem_cnt_d == len_q) ? DONE : FETCH;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         elem_cnt_q <= '0;
         bit_cnt_q  <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         elem_cnt_q <= elem_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
      end
   end

   // The multiplier only iterates in MULT; every other state reloads it.
   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == FETCH);
   assign out_valid = (state_q == DONE);
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_s     = (state_q == MULT);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: two instances (ACC_W 20 and 16) run in
// lockstep, each beside a behavioural model of the sequential multiplier.
module tb_dot_product_accumulator;

   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             rst, start, in_valid, out_ready;
   logic [LEN_W-1:0] len;
   logic [7:0]       in_a, in_b;

   logic        busy20, in_ready20, out_valid20, out_ovf20, mul_s20;
   logic [19:0] out_sum20;
   logic [7:0]  mul_a20, mul_b20;
   logic [15:0] mul_q20;

   logic        busy16, in_ready16, out_valid16, out_ovf16, mul_s16;
   logic [15:0] out_sum16;
   logic [7:0]  mul_a16, mul_b16;
   logic [15:0] mul_q16;

   int          total, bad, cyc;
   int          va[32], vb[32];
   logic [37:0] exp_q[$];   // {ovf16, sum16, ovf20, sum20}

   always #5 clk = ~clk;

   dot_product_accumulator #(.LEN_W(LEN_W), .ACC_W(20)) u_dut20 (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy20),
      .in_valid(in_valid), .in_ready(in_ready20), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid20), .out_ready(out_ready), .out_sum(out_sum20),
      .out_ovf(out_ovf20), .mul_a(mul_a20), .mul_b(mul_b20), .mul_s(mul_s20),
      .mul_q(mul_q20)
   );

   dot_product_accumulator #(.LEN_W(LEN_W), .ACC_W(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy16),
      .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid16), .out_ready(out_ready), .out_sum(out_sum16),
      .out_ovf(out_ovf16), .mul_a(mul_a16), .mul_b(mul_b16), .mul_s(mul_s16),
      .mul_q(mul_q16)
   );

   // Multiplier models: load on S=0, product valid only after exactly 8
   // iterations; any other count returns a junk pattern.
   logic signed [7:0]  ma20, mb20, ma16, mb16;
   logic signed [15:0] p20, p16;
   int                 it20, it16;

   always @(posedge clk) begin
      if (!mul_s20) begin ma20 <= mul_a20; mb20 <= mul_b20; it20 <= 0; end
      else it20 <= it20 + 1;
      if (!mul_s16) begin ma16 <= mul_a16; mb16 <= mul_b16; it16 <= 0; end
      else it16 <= it16 + 1;
   end
   assign p20     = ma20 * mb20;
   assign p16     = ma16 * mb16;
   assign mul_q20 = (it20 == 8) ? p20 : 16'h5A5A;
   assign mul_q16 = (it16 == 8) ? p16 : 16'h5A5A;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int wrap(input int t, input int w);
      int m, r;
      m = 1 << w;
      r = t % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   // Reference: plain integer dot product, wrapped per step at each width.
   function automatic logic [37:0] model(input int n);
      int s20 = 0, s16 = 0, p, t;
      bit o20 = 0, o16 = 0;
      logic [31:0] u20, u16;
      for (int i = 0; i < n; i++) begin
         p = va[i] * vb[i];
         t = s20 + p;
         if (t != wrap(t, 20)) o20 = 1;
         s20 = wrap(t, 20);
         t = s16 + p;
         if (t != wrap(t, 16)) o16 = 1;
         s16 = wrap(t, 16);
      end
      u20 = s20;
      u16 = s16;
      return {o16, u16[15:0], o20, u20[19:0]};
   endfunction

   function automatic int rnd_op();
      case ($urandom_range(0, 5))
         0:       return -128;
         1:       return 127;
         default: return int'($urandom_range(0, 255)) - 128;
      endcase
   endfunction

   // Monitor: pops one expected result per completed output handshake.
   always @(negedge clk) begin
      logic [37:0] e;
      if (!rst && (out_valid20 || out_valid16)) begin
         chk("valid_lockstep", 32'(out_valid16), 32'(out_valid20));
         if (out_ready && out_valid20) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got sum %0h with no expected entry", out_sum20);
            end else begin
               e = exp_q.pop_front();
               chk("sum20", 32'(out_sum20), 32'(e[19:0]));
               chk("ovf20", 32'(out_ovf20), 32'(e[20]));
               chk("sum16", 32'(out_sum16), 32'(e[36:21]));
               chk("ovf16", 32'(out_ovf16), 32'(e[37]));
            end
         end
      end
   end

   task automatic check_idle();
      chk("rst_busy", 32'(busy20), 0);
      chk("rst_in_ready", 32'(in_ready20), 0);
      chk("rst_out_valid", 32'(out_valid20), 0);
      chk("rst_ovf", 32'(out_ovf20), 0);
      chk("rst_mul_s", 32'(mul_s20), 0);
      chk("rst_sum", 32'(out_sum20), 0);
      chk("rst_mul_a", 32'(mul_a20), 0);
      chk("rst_mul_b", 32'(mul_b20), 0);
      chk("rst_sum16", 32'(out_sum16), 0);
   endtask

   // Runs one vector from va/vb: g>0 keeps in_valid low for the first g
   // cycles, hold delays out_ready, sb pulses start while busy.
   task automatic run_vec(input int n, input int g, input int hold, input bit sb);
      logic [37:0] e;
      int i, lat_exp;
      bit hs, saw_ready;
      e = model(n);
      exp_q.push_back(e);
      lat_exp = 1 + 11 * n + ((g > 0) ? g - 1 : 0);
      start = 1; len = LEN_W'(n); out_ready = (hold == 0);
      i = 0; in_valid = (g == 0) && (n > 0);
      in_a = 8'(va[0]); in_b = 8'(vb[0]);
      cyc = 0; saw_ready = 0;
      while (!out_valid20 && cyc < 600) begin
         hs = in_valid && in_ready20;
         tick();
         start = 0;
         if (in_ready20) saw_ready = 1;
         if (sb && cyc == 4) begin start = 1; len = LEN_W'(7); end
         if (hs) begin
            i++;
            in_valid = (i < n);
            if (i < n) begin in_a = 8'(va[i]); in_b = 8'(vb[i]); end
         end
         if (g > 0 && cyc == g && i == 0) in_valid = (n > 0);
      end
      chk("latency", cyc, lat_exp);
      chk("pairs_consumed", i, n);
      if (n == 0) chk("no_in_ready", 32'(saw_ready), 0);
      for (int k = 0; k < hold; k++) begin
         chk("hold_valid", 32'(out_valid20), 1);
         chk("hold_sum", 32'(out_sum20), 32'(e[19:0]));
         tick();
      end
      out_ready = 1;
      tick();
      chk("valid_drop", 32'(out_valid20), 0);
      chk("idle_after", 32'(busy20), 0);
   endtask

   initial begin
      int i;
      bit hs;
      total = 0; bad = 0; cyc = 0;
      rst = 1; start = 0; len = '0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 0;
      tick(); tick();
      check_idle();
      rst = 0;
      tick();

      // Basic three-element vector with a held result.
      va[0] = 3;  vb[0] = 4;
      va[1] = -5; vb[1] = 6;
      va[2] = 7;  vb[2] = -8;
      run_vec(3, 0, 4, 0);

      // Most negative operand corner cases.
      va[0] = -128; vb[0] = -128;
      run_vec(1, 0, 0, 0);
      va[0] = -128; vb[0] = 127;
      run_vec(1, 0, 0, 0);

      // Empty vector.
      run_vec(0, 0, 0, 0);

      // Input stall of five FETCH cycles plus output hold.
      for (int k = 0; k < 3; k++) begin va[k] = rnd_op(); vb[k] = rnd_op(); end
      run_vec(3, 6, 4, 0);

      // Reset while element 2 of 4 is in the multiplier.
      for (int k = 0; k < 4; k++) begin va[k] = rnd_op(); vb[k] = rnd_op(); end
      start = 1; len = LEN_W'(4); out_ready = 1;
      in_valid = 1; in_a = 8'(va[0]); in_b = 8'(vb[0]);
      cyc = 0; i = 0;
      while (i < 2 && cyc < 100) begin
         hs = in_valid && in_ready20;
         tick();
         start = 0;
         if (hs) begin i++; in_a = 8'(va[i]); in_b = 8'(vb[i]); end
      end
      tick(); tick(); tick();
      chk("abort_in_mult", 32'(mul_s20), 1);
      rst = 1; in_valid = 0;
      tick();
      check_idle();
      rst = 0;
      tick();
      for (int k = 0; k < 2; k++) begin va[k] = rnd_op(); vb[k] = rnd_op(); end
      run_vec(2, 0, 0, 0);

      // Overflow at 16 bits, with a start pulse while busy.
      for (int k = 0; k < 3; k++) begin va[k] = -128; vb[k] = -128; end
      run_vec(3, 0, 0, 1);

      // Maximum length.
      for (int k = 0; k < 31; k++) begin va[k] = -128; vb[k] = -128; end
      run_vec(31, 0, 1, 0);

      // Random vectors.
      for (int r = 0; r < 20; r++) begin
         int n;
         n = $urandom_range(0, 8);
         for (int k = 0; k < n; k++) begin va[k] = rnd_op(); vb[k] = rnd_op(); end
         run_vec(n, ($urandom_range(0, 3) == 0) ? 3 : 0, $urandom_range(0, 2),
                 bit'(n > 0 && $urandom_range(0, 1) == 1));
      end

      tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
